// File: rtl/fifo_rr_reader_if.sv
// Signal bundle between fifo_rr_reader, its source FIFO bank and the downstream sink.
// pop_count is present only when RD_POP_COUNT_EN is defined.
interface fifo_rr_reader_if #(
  parameter int DATA_WIDTH   = 10,
  parameter int NUM_FIFOS    = 4,
  parameter int THRESH_WIDTH = 3
);
  logic                            init;
  logic [THRESH_WIDTH-1:0]         umbral_alto_in;
  logic [THRESH_WIDTH-1:0]         umbral_bajo_in;
  logic [THRESH_WIDTH-1:0]         umbral_alto_out;
  logic [THRESH_WIDTH-1:0]         umbral_bajo_out;
  logic [NUM_FIFOS-1:0]            fifo_empty;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_in;
  logic [NUM_FIFOS-1:0]            fifo_pop;
  logic                            down_almost_full;
  logic                            down_full;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_valid;
  logic [1:0]                      state;
  logic                            idle;
  logic                            error;
`ifdef RD_POP_COUNT_EN
  logic [15:0]                     pop_count;
`endif

  // Reader side
  modport master (
`ifdef RD_POP_COUNT_EN
    output pop_count,
`endif
    input  init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_data_in,
           down_almost_full, down_full,
    output umbral_alto_out, umbral_bajo_out, fifo_pop, out_data, out_valid,
           state, idle, error
  );

  // FIFO bank / sink / control side
  modport slave (
`ifdef RD_POP_COUNT_EN
    input  pop_count,
`endif
    output init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_data_in,
           down_almost_full, down_full,
    input  umbral_alto_out, umbral_bajo_out, fifo_pop, out_data, out_valid,
           state, idle, error
  );
endinterface

// File: rtl/fifo_rr_reader.sv
// Round-robin read controller for a FIFO bank: loads thresholds, pops non-empty FIFOs
// and forwards one valid-qualified stream. Optional pop counter: RD_POP_COUNT_EN.
module fifo_rr_reader #(
  parameter int DATA_WIDTH   = 10,
  parameter int NUM_FIFOS    = 4,
  parameter int THRESH_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  fifo_rr_reader_if.master bus
);

  localparam int PTR_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    error_q, error_d;
  logic [THRESH_WIDTH-1:0] alto_q, bajo_q;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]        sel_q;
  logic [NUM_FIFOS-1:0]    last_pop_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic [NUM_FIFOS-1:0]    eligible;
  logic [NUM_FIFOS-1:0]    pop;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic                    idle;
  logic [DATA_WIDTH-1:0]   words [NUM_FIFOS];
  logic [DATA_WIDTH-1:0]   out_data;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_unpack
    assign words[g] = bus.fifo_data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  // A failed INIT exit flags the error and keeps waiting for a valid threshold pair
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!bus.init) begin
          if (bajo_q < alto_q) begin
            state_d = ST_IDLE;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.init)                  state_d = ST_INIT;
        else if (!(&bus.fifo_empty))   state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)                  state_d = ST_INIT;
        else if (&bus.fifo_empty)      state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // The empty flag lags a pop by one cycle, so a FIFO popped last cycle is skipped
  always_comb begin
    pop       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    eligible  = ~bus.fifo_empty & ~last_pop_q;
    idle      = (state_q == ST_IDLE);
    if (state_q == ST_ACTIVE && !bus.init && !bus.down_almost_full && !bus.down_full) begin
      for (int k = 0; k < NUM_FIFOS; k++) begin
        cand = PTR_W'((int'(rr_q) + k) % NUM_FIFOS);
        if (!grant_vld && eligible[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      if (int'(grant_idx) == NUM_FIFOS - 1) rr_d = '0;
      else                                  rr_d = grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      sel_q      <= '0;
      last_pop_q <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
      alto_q     <= '0;
      bajo_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      last_pop_q <= pop;
      valid_q    <= grant_vld;
      if (grant_vld) sel_q <= grant_idx;
      if (valid_q)   hold_q <= words[sel_q];
      if (state_q == ST_INIT && bus.init) begin
        alto_q <= bus.umbral_alto_in;
        bajo_q <= bus.umbral_bajo_in;
      end
    end
  end

  // Word is taken from the FIFO output one cycle after its pop, then held
  assign out_data = valid_q ? words[sel_q] : hold_q;

  assign bus.fifo_pop        = pop;
  assign bus.out_valid       = valid_q;
  assign bus.out_data        = out_data;
  assign bus.state           = state_q;
  assign bus.idle            = idle;
  assign bus.error           = error_q;
  assign bus.umbral_alto_out = alto_q;
  assign bus.umbral_bajo_out = bajo_q;

`ifdef RD_POP_COUNT_EN
  logic [15:0] pop_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count_q <= '0;
    end else if (state_d == ST_INIT && state_q != ST_INIT) begin
      pop_count_q <= '0;
    end else if (valid_q && pop_count_q != 16'hFFFF) begin
      pop_count_q <= pop_count_q + 16'd1;
    end
  end

  assign bus.pop_count = pop_count_q;
`else
  // Counter omitted in this build
`endif

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Self-checking bench for fifo_rr_reader: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the reader and its FIFO bank.
module tb_fifo_rr_reader;

  localparam int DW = 10;
  localparam int NF = 4;
  localparam int TW = 3;

  localparam int S_RESET  = 0;
  localparam int S_INIT   = 1;
  localparam int S_IDLE   = 2;
  localparam int S_ACTIVE = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_rr_reader_if #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .THRESH_WIDTH(TW)) bus ();

  fifo_rr_reader #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .THRESH_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus knobs
  bit rstV, initV, afV, fullV;
  int altoV, bajoV;

  // FIFO bank environment
  int            fifoCount [NF];
  bit            envEmpty  [NF];
  logic [DW-1:0] dataIn    [NF];

  // reference model
  int            mState, mRr, mLastIdx, mSel, mAlto, mBajo, mPopCount;
  bit            mValid, mErr;
  logic [DW-1:0] mHold;

  int popLog[$];
  int popCyc[$];
  int validCount;
  int cycleNo = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  function automatic void modelReset();
    mState    = S_RESET;
    mRr       = 0;
    mLastIdx  = -1;
    mSel      = 0;
    mValid    = 1'b0;
    mErr      = 1'b0;
    mHold     = '0;
    mAlto     = 0;
    mBajo     = 0;
    mPopCount = 0;
  endfunction

  function automatic int expectedGrant();
    int order[$];
    if (mState != S_ACTIVE || initV || afV || fullV) return -1;
    for (int k = 0; k < NF; k++) order.push_back((mRr + k) % NF);
    foreach (order[j])
      if (!envEmpty[order[j]] && order[j] != mLastIdx) return order[j];
    return -1;
  endfunction

  function automatic void modelAdvance(input int g, input logic [NF-1:0] obsPop);
    bit anyFull;
    bit oldValid;
    int prevState;
    if (rstV) begin
      modelReset();
      return;
    end
    anyFull = 1'b0;
    for (int i = 0; i < NF; i++) if (!envEmpty[i]) anyFull = 1'b1;
    oldValid  = mValid;
    prevState = mState;
    if (mValid) mHold = dataIn[mSel];
    mValid   = (g >= 0);
    mLastIdx = g;
    if (g >= 0) begin
      mSel = g;
      mRr  = (g + 1) % NF;
    end
    case (mState)
      S_RESET: mState = S_INIT;
      S_INIT: begin
        if (initV) begin
          mAlto = altoV;
          mBajo = bajoV;
        end else if (mBajo < mAlto) begin
          mState = S_IDLE;
          mErr   = 1'b0;
        end else begin
          mErr = 1'b1;
        end
      end
      S_IDLE:   if (initV) mState = S_INIT; else if (anyFull) mState = S_ACTIVE;
      default:  if (initV) mState = S_INIT; else if (!anyFull) mState = S_IDLE;
    endcase
    if (mState == S_INIT && prevState != S_INIT) mPopCount = 0;
    else if (oldValid && mPopCount < 65535)     mPopCount++;
    // FIFO bank: empty flag reflects the occupancy seen before this edge's pop
    for (int i = 0; i < NF; i++) begin
      envEmpty[i] = (fifoCount[i] == 0);
      if (obsPop[i] && fifoCount[i] > 0) fifoCount[i]--;
    end
  endfunction

  task automatic applyStimulus();
    int            g;
    logic [NF-1:0] obsPop;
    @(negedge clk);
    reset                = rstV;
    bus.init             = initV;
    bus.umbral_alto_in   = TW'(altoV);
    bus.umbral_bajo_in   = TW'(bajoV);
    bus.down_almost_full = afV;
    bus.down_full        = fullV;
    for (int i = 0; i < NF; i++) begin
      bus.fifo_empty[i]               = envEmpty[i];
      bus.fifo_data_in[i*DW +: DW]    = dataIn[i];
    end
    #1;
    g = expectedGrant();
    checkOutput("fifo_pop", 32'(bus.fifo_pop), (g < 0) ? 32'd0 : (32'd1 << g));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
    checkOutput("out_data", 32'(bus.out_data), 32'(mValid ? dataIn[mSel] : mHold));
    checkOutput("state", 32'(bus.state), 32'(mState));
    checkOutput("idle", 32'(bus.idle), 32'(mState == S_IDLE));
    checkOutput("error", 32'(bus.error), 32'(mErr));
    checkOutput("umbral_alto_out", 32'(bus.umbral_alto_out), 32'(mAlto));
    checkOutput("umbral_bajo_out", 32'(bus.umbral_bajo_out), 32'(mBajo));
`ifdef RD_POP_COUNT_EN
    checkOutput("pop_count", 32'(bus.pop_count), 32'(mPopCount));
`endif
    obsPop = bus.fifo_pop;
    for (int i = 0; i < NF; i++) begin
      if (obsPop[i]) begin
        popLog.push_back(i);
        popCyc.push_back(cycleNo);
      end
    end
    if (bus.out_valid) validCount++;
    @(posedge clk);
    modelAdvance(g, obsPop);
    cycleNo++;
  endtask

  task automatic runCycles(input int n, input bit randData);
    for (int c = 0; c < n; c++) begin
      if (randData) for (int i = 0; i < NF; i++) dataIn[i] = DW'($urandom());
      applyStimulus();
    end
  endtask

  task automatic loadFifo(input int idx, input int words);
    fifoCount[idx] = words;
    envEmpty[idx]  = (words == 0);
  endtask

  task automatic clearLogs();
    popLog.delete();
    popCyc.delete();
    validCount = 0;
  endtask

  int expOrder3[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int expOrder5[3] = '{3, 0, 1};
  int initLeft;

  initial begin
    rstV = 1'b1; initV = 1'b1; altoV = 6; bajoV = 2; afV = 1'b0; fullV = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NF; i++) begin
      loadFifo(i, 0);
      dataIn[i] = DW'(32'h10 + i);
    end
    modelReset();
    clearLogs();

    // 1: reset, load 6/2, exit INIT
    runCycles(2, 1'b0);
    rstV = 1'b0;
    runCycles(2, 1'b0);
    initV = 1'b0;
    runCycles(2, 1'b0);
    #2;
    checkOutput("t1 alto", 32'(bus.umbral_alto_out), 32'd6);
    checkOutput("t1 bajo", 32'(bus.umbral_bajo_out), 32'd2);
    checkOutput("t1 state", 32'(bus.state), S_IDLE);
    checkOutput("t1 idle", 32'(bus.idle), 32'd1);
    checkOutput("t1 error", 32'(bus.error), 32'd0);

    // 2: bad thresholds then recovery
    initV = 1'b1; altoV = 2; bajoV = 5;
    runCycles(2, 1'b0);
    initV = 1'b0;
    runCycles(2, 1'b0);
    #2;
    checkOutput("t2 error set", 32'(bus.error), 32'd1);
    checkOutput("t2 stuck INIT", 32'(bus.state), S_INIT);
    initV = 1'b1; altoV = 6; bajoV = 1;
    runCycles(2, 1'b0);
    initV = 1'b0;
    runCycles(1, 1'b0);
    #2;
    checkOutput("t2 recovered", 32'(bus.state), S_IDLE);
    checkOutput("t2 error clr", 32'(bus.error), 32'd0);

    // 3: four FIFOs, two words each
    clearLogs();
    for (int i = 0; i < NF; i++) loadFifo(i, 2);
    runCycles(14, 1'b0);
    checkOutput("t3 pop total", 32'(popLog.size()), 32'd8);
    checkOutput("t3 valid total", 32'(validCount), 32'd8);
    foreach (expOrder3[j])
      if (j < popLog.size()) checkOutput("t3 pop order", 32'(popLog[j]), 32'(expOrder3[j]));
    if (popCyc.size() == 8) checkOutput("t3 back-to-back", 32'(popCyc[7] - popCyc[0]), 32'd7);
    #2;
    checkOutput("t3 back to IDLE", 32'(bus.state), S_IDLE);

    // 4: single FIFO, three words
    clearLogs();
    loadFifo(2, 3);
    runCycles(10, 1'b0);
    checkOutput("t4 pop total", 32'(popLog.size()), 32'd3);
    checkOutput("t4 valid total", 32'(validCount), 32'd3);
    foreach (popLog[j]) checkOutput("t4 pop idx", 32'(popLog[j]), 32'd2);
    if (popCyc.size() == 3) begin
      checkOutput("t4 gap a", 32'(popCyc[1] - popCyc[0]), 32'd2);
      checkOutput("t4 gap b", 32'(popCyc[2] - popCyc[1]), 32'd2);
    end

    // 5: almost-full stall mid-stream, resume at next rr position
    clearLogs();
    for (int i = 0; i < NF; i++) loadFifo(i, 4);
    runCycles(3, 1'b1);
    afV = 1'b1;
    runCycles(3, 1'b1);
    afV = 1'b0;
    runCycles(1, 1'b1);
    checkOutput("t5 pop total", 32'(popLog.size()), 32'd3);
    foreach (expOrder5[j])
      if (j < popLog.size()) checkOutput("t5 pop order", 32'(popLog[j]), 32'(expOrder5[j]));
    checkOutput("t5 inflight emitted", 32'(validCount), 32'd2);
    runCycles(30, 1'b1);

    // randomized traffic with backpressure and occasional re-init
    initLeft = 0;
    for (int c = 0; c < 500; c++) begin
      afV   = ($urandom_range(0, 7) == 0);
      fullV = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NF; i++)
        if (envEmpty[i] && fifoCount[i] == 0 && $urandom_range(0, 3) == 0)
          fifoCount[i] = $urandom_range(1, 4);
      if (initLeft > 0) begin
        initLeft--;
        initV = (initLeft > 0);
      end else if ($urandom_range(0, 59) == 0 || (mErr && mState == S_INIT)) begin
        bajoV = $urandom_range(0, 3);
        altoV = ($urandom_range(0, 3) == 0) ? bajoV : bajoV + $urandom_range(1, 3);
        initLeft = 3;
        initV = 1'b1;
      end
      runCycles(1, 1'b1);
    end
    initV = 1'b0; afV = 1'b0; fullV = 1'b0;
    altoV = 6; bajoV = 2;
    initV = 1'b1;
    runCycles(2, 1'b1);
    initV = 1'b0;
    runCycles(2, 1'b1);

    // 6: asynchronous reset in the middle of a stream
    for (int i = 0; i < NF; i++) loadFifo(i, 4);
    runCycles(4, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6 pop", 32'(bus.fifo_pop), 32'd0);
    checkOutput("t6 valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6 data", 32'(bus.out_data), 32'd0);
    checkOutput("t6 state", 32'(bus.state), S_RESET);
    checkOutput("t6 idle", 32'(bus.idle), 32'd0);
    checkOutput("t6 alto", 32'(bus.umbral_alto_out), 32'd0);
    rstV = 1'b1; initV = 1'b1;
    modelReset();
    runCycles(2, 1'b1);
    rstV = 1'b0;
    runCycles(1, 1'b1);
    #2;
    checkOutput("t6 INIT after release", 32'(bus.state), S_INIT);
    runCycles(1, 1'b1);
    initV = 1'b0;
    runCycles(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
